spi_tx: RTL and testbench

SPI master transmitter. Accepts words on an AXI-Stream slave port and serialises each word MSB-first on txd. Generates sclk and an active-low chip select at a runtime-programmable rate. Pairs with the team's SPI receiver; spi_tx → spi_rx loopback with the same SPI_MODE must be lossless.

---
 rtl/spi_pkg.sv | 19 +
 rtl/spi_tx_if.sv | 17 +
 rtl/spi_clk_gen.sv | 35 +++
 rtl/spi_tx.sv | 136 +++++++++++++
 tb/tb_spi_tx.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI types and mode helpers for spi_tx and spi_rx
package spi_pkg;

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} spi_tx_state_t;

  function automatic logic spi_cpol(input int unsigned mode);
    return mode[1];
  endfunction

  function automatic logic spi_cpha(input int unsigned mode);
    return mode[0];
  endfunction

  // Modes 0 and 3 sample on the rising sclk edge, modes 1 and 2 on the falling one.
  function automatic logic spi_sample_rising(input int unsigned mode);
    return spi_cpol(mode) == spi_cpha(mode);
  endfunction

endpackage

// File: rtl/spi_tx_if.sv
// rtl/spi_tx_if.sv - word stream into spi_tx; SPI_TX_BURST_EN adds tlast
interface spi_tx_if #(parameter int DATA_WIDTH = 8);

  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
`ifdef SPI_TX_BURST_EN
  logic                  tlast;

  modport master (output tdata, tvalid, tlast, input tready);
  modport slave  (input tdata, tvalid, tlast, output tready);
`else
  modport master (output tdata, tvalid, input tready);
  modport slave  (input tdata, tvalid, output tready);
`endif

endinterface

// File: rtl/spi_clk_gen.sv
// rtl/spi_clk_gen.sv - prescale down-counter, one-cycle tick every prescale+1 cycles
module spi_clk_gen #(
  parameter int PRESCALE_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load,
  input  logic                      en,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  output logic                      tick,
  output logic                      tick_next
);

  localparam logic [PRESCALE_WIDTH-1:0] ONE = PRESCALE_WIDTH'(1);

  logic [PRESCALE_WIDTH-1:0] period_q;
  logic [PRESCALE_WIDTH-1:0] cnt_q;

  // Counting down to zero and reloading keeps prescale = all-ones inside the register width.
  always_ff @(posedge clk) begin
    if (rst) begin
      period_q <= '0;
      cnt_q    <= '0;
    end else if (load) begin
      period_q <= prescale;
      cnt_q    <= prescale;
    end else if (en) begin
      cnt_q <= (cnt_q == '0) ? period_q : cnt_q - ONE;
    end
  end

  assign tick      = en && (cnt_q == '0);
  assign tick_next = en && ((cnt_q == '0) ? (period_q == '0) : (cnt_q == ONE));

endmodule

// File: rtl/spi_tx.sv
// rtl/spi_tx.sv - SPI master transmitter, MSB first; SPI_TX_BURST_EN keeps cs_n low across tlast=0 words
module spi_tx
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int SPI_MODE       = 0,
  parameter int PRESCALE_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  spi_tx_if.slave                   s_axis,
  output logic                      sclk,
  output logic                      txd,
  output logic                      cs_n,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  output logic                      busy
);

  localparam logic CPOL = spi_cpol(SPI_MODE);
  localparam logic CPHA = spi_cpha(SPI_MODE);
  localparam int   EW   = $clog2(2 * DATA_WIDTH) + 1;
  localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DATA_WIDTH - 1);
  localparam logic [EW-1:0] EDGE_ONE  = EW'(1);

`ifdef SPI_TX_BURST_EN
  localparam bit BURST = 1'b1;
  logic last_in;
  assign last_in = s_axis.tlast;
`else
  localparam bit BURST = 1'b0;
  logic last_in;
  assign last_in = 1'b1;
`endif

  spi_tx_state_t         state_q, state_d;
  logic [DATA_WIDTH-1:0] sh_q, sh_d;
  logic [EW-1:0]         edge_q, edge_d;
  logic                  sclk_q, sclk_d;
  logic                  txd_q, txd_d;
  logic                  cs_n_q, cs_n_d;
  logic                  busy_q, busy_d;
  logic                  tready_q, tready_d;
  logic                  last_q, last_d;
  logic                  load, tick, tick_next, accept;

  assign accept = s_axis.tvalid && tready_q;

  spi_clk_gen #(.PRESCALE_WIDTH(PRESCALE_WIDTH)) u_clk_gen (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .en        (state_q != IDLE),
    .prescale  (prescale),
    .tick      (tick),
    .tick_next (tick_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      sh_q     <= '0;
      edge_q   <= '0;
      sclk_q   <= CPOL;
      txd_q    <= 1'b1;
      cs_n_q   <= 1'b1;
      busy_q   <= 1'b0;
      tready_q <= 1'b0;
      last_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      sh_q     <= sh_d;
      edge_q   <= edge_d;
      sclk_q   <= sclk_d;
      txd_q    <= txd_d;
      cs_n_q   <= cs_n_d;
      busy_q   <= busy_d;
      tready_q <= tready_d;
      last_q   <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    edge_d  = edge_q;
    sclk_d  = sclk_q;
    txd_d   = txd_q;
    last_d  = last_q;
    load    = 1'b0;

    case (state_q)
      IDLE, HOLD: begin
        // A HOLD acceptance only happens mid-burst, where tready is raised for the last HOLD cycle.
        if (accept) begin
          state_d = SETUP;
          load    = 1'b1;
          last_d  = last_in;
          edge_d  = '0;
          sh_d    = CPHA ? s_axis.tdata : (s_axis.tdata << 1);
          txd_d   = CPHA ? 1'b1 : s_axis.tdata[DATA_WIDTH-1];
        end else if (state_q == HOLD && tick && last_q) begin
          state_d = GAP;
          txd_d   = 1'b1;
        end
      end
      SETUP, SHIFT: begin
        if (tick) begin
          sclk_d = ~sclk_q;
          edge_d = edge_q + EDGE_ONE;
          // edge_q[0]==0 means the toggle being made is a leading (odd) one.
          if (CPHA ? !edge_q[0] : (edge_q[0] && edge_q != LAST_EDGE)) begin
            txd_d = sh_q[DATA_WIDTH-1];
            sh_d  = sh_q << 1;
          end
          state_d = (edge_q == LAST_EDGE) ? HOLD : SHIFT;
        end
      end
      GAP: begin
        if (tick) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    cs_n_d   = !(state_d == SETUP || state_d == SHIFT || state_d == HOLD);
    busy_d   = state_d != IDLE;
    tready_d = (state_d == IDLE) ||
               (BURST && state_d == HOLD && !last_q && (tready_q || tick_next));
  end

  assign s_axis.tready = tready_q;
  assign sclk          = sclk_q;
  assign txd           = txd_q;
  assign cs_n          = cs_n_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_spi_tx.sv
// tb/tb_spi_tx.sv - self-checking bench for spi_tx, all four SPI modes side by side
module tb_spi_tx;

  logic        clk;
  logic        rst;
  logic        tvalid;
  logic [7:0]  tdata;
`ifdef SPI_TX_BURST_EN
  logic        tlast;
`endif
  logic [15:0] prescale;
  logic [3:0]  sclk, txd, cs_n, busy, tready;

  int n_checks;
  int n_fails;
  int words_done;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  for (genvar m = 0; m < 4; m++) begin : g_mode
    localparam bit SAMPLE_RISE = (m == 0) || (m == 3);

    spi_tx_if #(.DATA_WIDTH(8)) bus ();
    assign bus.tdata  = tdata;
    assign bus.tvalid = tvalid;
`ifdef SPI_TX_BURST_EN
    assign bus.tlast  = tlast;
`endif
    assign tready[m]  = bus.tready;

    spi_tx #(.DATA_WIDTH(8), .SPI_MODE(m), .PRESCALE_WIDTH(16)) dut (
      .clk      (clk),
      .rst      (rst),
      .s_axis   (bus),
      .sclk     (sclk[m]),
      .txd      (txd[m]),
      .cs_n     (cs_n[m]),
      .prescale (prescale),
      .busy     (busy[m])
    );

    logic [7:0] exp_q[$];
    logic [7:0] rx_sh;
    logic [7:0] exp_w;
    int         rx_bits;
    int         rx_cnt;
    logic       prev_sclk;

    initial begin
      rx_bits   = 0;
      rx_cnt    = 0;
      rx_sh     = '0;
      prev_sclk = (m >= 2);
      forever begin
        @(negedge clk);
        #1;
        if (rst) begin
          exp_q.delete();
          rx_bits = 0;
        end else begin
          if (tvalid && tready[m]) exp_q.push_back(tdata);
          if (cs_n[m]) begin
            rx_bits = 0;
          end else if (sclk[m] != prev_sclk && sclk[m] == SAMPLE_RISE) begin
            rx_sh = {rx_sh[6:0], txd[m]};
            rx_bits++;
            if (rx_bits == 8) begin
              rx_bits = 0;
              rx_cnt++;
              if (exp_q.size() == 0) begin
                check($sformatf("rx m%0d unexpected word", m), 32'(rx_sh), 32'hFFFF_FFFF);
              end else begin
                exp_w = exp_q.pop_front();
                check($sformatf("rx m%0d word", m), 32'(rx_sh), 32'(exp_w));
              end
            end
          end
        end
        prev_sclk = sclk[m];
      end
    end
  end

  // {sclk, txd, cs_n, busy, tready} expected rel cycles after acceptance.
  function automatic logic [4:0] model(input int m, input logic [7:0] d, input int h,
                                       input int rel, input bit last);
    int tog, lead, idx, end_c;
    bit cpol, cpha, in_frame, tx, by, tr;
    logic sc;
    cpol  = (m >= 2);
    cpha  = (m % 2) == 1;
    end_c = last ? 1 + 18 * h : 17 * h;
    tog   = (rel - 1) / h;
    if (tog > 16) tog = 16;
    sc       = cpol ^ tog[0];
    in_frame = last ? (rel < 1 + 17 * h) : 1'b1;
    by       = last ? (rel < end_c) : 1'b1;
    tr       = last ? (rel >= end_c) : (rel == end_c);
    if (!in_frame) begin
      tx = 1'b1;
    end else if (!cpha) begin
      idx = 7 - (((tog / 2) > 7) ? 7 : (tog / 2));
      tx  = d[idx];
    end else begin
      lead = (tog + 1) / 2;
      tx   = (lead == 0) ? 1'b1 : d[8 - lead];
    end
    return {sc, tx, !in_frame, by, tr};
  endfunction

  task automatic run_frame(input logic [7:0] d, input bit last, input int h,
                           input bit keep_valid, input logic [7:0] next_d, input bit next_last,
                           input logic [15:0] new_presc, input int abort_rel);
    int w;
    int end_c;
    tdata  = d;
    tvalid = 1'b1;
`ifdef SPI_TX_BURST_EN
    tlast  = last;
`endif
    w = 0;
    while (!tready[0] && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (w >= 300) begin
      check("accept timeout", 32'd0, 32'd1);
      tvalid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    tvalid = keep_valid;
    end_c  = last ? 1 + 18 * h : 17 * h;
    for (int rel = 1; rel <= end_c; rel++) begin
      if (rel > 1) @(negedge clk);
      for (int m = 0; m < 4; m++) begin
        check($sformatf("frame %0h m%0d rel %0d", d, m, rel),
              32'({sclk[m], txd[m], cs_n[m], busy[m], tready[m]}),
              32'(model(m, d, h, rel, last)));
      end
      if (rel == 5) begin
        tdata    = ~d;
        tvalid   = 1'b1;
        prescale = new_presc;
      end
      if (rel == abort_rel) begin
        rst    = 1'b1;
        tvalid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("abort sclk", 32'(sclk), 32'h0C);
        check("abort txd", 32'(txd), 32'h0F);
        check("abort cs_n", 32'(cs_n), 32'h0F);
        check("abort busy", 32'(busy), 32'h00);
        @(negedge clk);
        rst = 1'b0;
        return;
      end
    end
    tdata  = next_d;
    tvalid = keep_valid;
`ifdef SPI_TX_BURST_EN
    tlast  = next_last;
`endif
    words_done++;
  endtask

  initial begin
    n_checks   = 0;
    n_fails    = 0;
    words_done = 0;
    rst        = 1'b1;
    tvalid     = 1'b0;
    tdata      = '0;
    prescale   = 16'd1;
`ifdef SPI_TX_BURST_EN
    tlast      = 1'b1;
`endif
    repeat (3) @(negedge clk);
    check("reset tready", 32'(tready), 32'h00);
    check("reset sclk", 32'(sclk), 32'h0C);
    check("reset txd", 32'(txd), 32'h0F);
    check("reset cs_n", 32'(cs_n), 32'h0F);
    check("reset busy", 32'(busy), 32'h00);
    rst = 1'b0;
    @(negedge clk);
    check("tready after reset", 32'(tready), 32'h0F);

    run_frame(8'hA5, 1'b1, 2, 1'b0, 8'h00, 1'b1, 16'd1, 0);

    prescale = 16'd0;
    run_frame(8'h3C, 1'b1, 1, 1'b0, 8'h00, 1'b1, 16'd0, 0);
    run_frame(8'hFF, 1'b1, 1, 1'b0, 8'h00, 1'b1, 16'd0, 0);
    run_frame(8'h00, 1'b1, 1, 1'b0, 8'h00, 1'b1, 16'd0, 0);

    prescale = 16'd2;
    run_frame(8'h81, 1'b1, 3, 1'b1, 8'h42, 1'b1, 16'd2, 0);
    run_frame(8'h42, 1'b1, 3, 1'b1, 8'hE7, 1'b1, 16'd2, 0);
    run_frame(8'hE7, 1'b1, 3, 1'b1, 8'h18, 1'b1, 16'd2, 0);
    run_frame(8'h18, 1'b1, 3, 1'b0, 8'h00, 1'b1, 16'd2, 0);

    prescale = 16'd1;
    run_frame(8'h5A, 1'b1, 2, 1'b0, 8'h00, 1'b1, 16'd1, 10);
    run_frame(8'hC3, 1'b1, 2, 1'b0, 8'h00, 1'b1, 16'd1, 0);

    run_frame(8'h96, 1'b1, 2, 1'b0, 8'h00, 1'b1, 16'd5, 0);
    run_frame(8'h69, 1'b1, 6, 1'b0, 8'h00, 1'b1, 16'd5, 0);

`ifdef SPI_TX_BURST_EN
    prescale = 16'd1;
    @(negedge clk);
    run_frame(8'h12, 1'b0, 2, 1'b1, 8'h34, 1'b1, 16'd1, 0);
    run_frame(8'h34, 1'b1, 2, 1'b0, 8'h00, 1'b1, 16'd1, 0);
`endif

    repeat (5) @(negedge clk);
    check("rx count m0", 32'(g_mode[0].rx_cnt), 32'(words_done));
    check("rx count m1", 32'(g_mode[1].rx_cnt), 32'(words_done));
    check("rx count m2", 32'(g_mode[2].rx_cnt), 32'(words_done));
    check("rx count m3", 32'(g_mode[3].rx_cnt), 32'(words_done));
    check("pending m0", 32'(g_mode[0].exp_q.size()), 32'd0);
    check("pending m1", 32'(g_mode[1].exp_q.size()), 32'd0);
    check("pending m2", 32'(g_mode[2].exp_q.size()), 32'd0);
    check("pending m3", 32'(g_mode[3].exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, expected completion before %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
